enemy_manager: RTL

Enemy pool stage directly downstream of the signal control unit. Consumes its one-cycle `Summon` spawn codes and its `is_game` level-active flag, maintains up to 8 live enemies (type, hit points, path position), advances them along the path, and applies tower hits. Counts enemies that reach the radish and returns `death` to the control unit when radish health is exhausted.

---
 rtl/enemy_manager.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_manager.sv
// enemy_manager: eight-slot enemy pool driven by the control unit's spawn codes.
// Advances enemies along the path once per step, applies tower hits and tracks radish health.
module enemy_manager #(
  parameter int unsigned STEP_CYCLES = 1000000,
  parameter int unsigned PATH_LEN    = 640,
  parameter int unsigned RADISH_HP   = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        is_game,
  input  logic [2:0]  Summon,
  input  logic        hit_valid,
  input  logic [2:0]  hit_slot,
  input  logic [7:0]  hit_dmg,
  output logic [7:0]  enemy_valid,
  output logic [23:0] enemy_type,
  output logic [79:0] enemy_pos,
  output logic [63:0] enemy_hp,
  output logic [3:0]  alive_count,
  output logic [3:0]  radish_hp,
  output logic        death,
  output logic        kill_pulse,
  output logic        leak_pulse,
  output logic        spawn_drop
);

  localparam int unsigned      CNT_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [10:0]      PATH_END    = 11'(PATH_LEN);
  localparam logic [3:0]       RADISH_INIT = 4'(RADISH_HP);

  function automatic logic code_valid(input logic [2:0] code);
    case (code)
      3'd1, 3'd2, 3'd6: code_valid = 1'b1;
      default:          code_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] type_hp(input logic [2:0] t);
    case (t)
      3'd1:    type_hp = 8'd20;
      3'd2:    type_hp = 8'd40;
      3'd6:    type_hp = 8'd100;
      default: type_hp = 8'd0;
    endcase
  endfunction

  function automatic logic [1:0] type_speed(input logic [2:0] t);
    case (t)
      3'd1:       type_speed = 2'd2;
      3'd2, 3'd6: type_speed = 2'd1;
      default:    type_speed = 2'd0;
    endcase
  endfunction

  function automatic logic [4:0] type_damage(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: type_damage = 5'd1;
      3'd6:       type_damage = 5'd3;
      default:    type_damage = 5'd0;
    endcase
  endfunction

  // Scanning from the top down leaves the lowest free index as the result.
  function automatic logic [2:0] lowest_free(input logic [7:0] v);
    lowest_free = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) lowest_free = 3'(i);
    end
  endfunction

  logic [7:0]       valid_r, valid_s;
  logic [2:0]       type_r [8];
  logic [2:0]       type_s [8];
  logic [9:0]       pos_r [8];
  logic [9:0]       pos_s [8];
  logic [7:0]       hp_r [8];
  logic [7:0]       hp_s [8];
  logic [3:0]       alive_r, alive_s;
  logic [3:0]       radish_r, radish_s;
  logic             kill_r, kill_s;
  logic             leak_r, leak_s;
  logic             drop_r, drop_s;
  logic [CNT_W-1:0] step_cnt_r, step_cnt_s;
  logic             is_game_r;
  logic             step_s;
  logic [4:0]       leak_sum_s;
  logic [10:0]      moved_s;
  logic [2:0]       spawn_slot_s;

  // Next-state of the pool: leak first, then hits on surviving slots, then spawn into a start-of-cycle free slot.
  always_comb begin
    valid_s      = valid_r;
    type_s       = type_r;
    pos_s        = pos_r;
    hp_s         = hp_r;
    kill_s       = 1'b0;
    leak_s       = 1'b0;
    drop_s       = 1'b0;
    leak_sum_s   = 5'd0;
    moved_s      = 11'd0;
    spawn_slot_s = lowest_free(valid_r);
    step_s       = is_game && (step_cnt_r == STEP_LAST);
    if (!is_game) begin
      valid_s = 8'd0;
      for (int i = 0; i < 8; i++) begin
        type_s[i] = 3'd0;
        pos_s[i]  = 10'd0;
        hp_s[i]   = 8'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        moved_s = {1'b0, pos_r[i]} + {9'd0, type_speed(type_r[i])};
        if (valid_r[i] && step_s && (moved_s >= PATH_END)) begin
          valid_s[i] = 1'b0;
          type_s[i]  = 3'd0;
          pos_s[i]   = 10'd0;
          hp_s[i]    = 8'd0;
          leak_sum_s = leak_sum_s + type_damage(type_r[i]);
          leak_s     = 1'b1;
        end else if (valid_r[i]) begin
          pos_s[i] = step_s ? moved_s[9:0] : pos_r[i];
          if (hit_valid && (hit_slot == 3'(i))) begin
            if (hit_dmg >= hp_r[i]) begin
              valid_s[i] = 1'b0;
              type_s[i]  = 3'd0;
              pos_s[i]   = 10'd0;
              hp_s[i]    = 8'd0;
              kill_s     = 1'b1;
            end else begin
              hp_s[i] = hp_r[i] - hit_dmg;
            end
          end else begin
            hp_s[i] = hp_r[i];
          end
        end else begin
          valid_s[i] = 1'b0;
        end
      end
      if (code_valid(Summon)) begin
        if (&valid_r) begin
          drop_s = 1'b1;
        end else begin
          valid_s[spawn_slot_s] = 1'b1;
          type_s[spawn_slot_s]  = Summon;
          pos_s[spawn_slot_s]   = 10'd0;
          hp_s[spawn_slot_s]    = type_hp(Summon);
        end
      end else begin
        drop_s = 1'b0;
      end
    end

    // Radish health is reloaded on level start, otherwise it only ever drops (and holds while idle).
    if (is_game && !is_game_r) begin
      radish_s = RADISH_INIT;
    end else if ({1'b0, radish_r} <= leak_sum_s) begin
      radish_s = 4'd0;
    end else begin
      radish_s = 4'({1'b0, radish_r} - leak_sum_s);
    end

    if (!is_game || (step_cnt_r == STEP_LAST)) begin
      step_cnt_s = '0;
    end else begin
      step_cnt_s = step_cnt_r + CNT_W'(1);
    end

    alive_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      alive_s = alive_s + {3'd0, valid_s[i]};
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_r    <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        type_r[i] <= 3'd0;
        pos_r[i]  <= 10'd0;
        hp_r[i]   <= 8'd0;
      end
      alive_r    <= 4'd0;
      radish_r   <= RADISH_INIT;
      kill_r     <= 1'b0;
      leak_r     <= 1'b0;
      drop_r     <= 1'b0;
      step_cnt_r <= '0;
      is_game_r  <= 1'b0;
    end else begin
      valid_r    <= valid_s;
      type_r     <= type_s;
      pos_r      <= pos_s;
      hp_r       <= hp_s;
      alive_r    <= alive_s;
      radish_r   <= radish_s;
      kill_r     <= kill_s;
      leak_r     <= leak_s;
      drop_r     <= drop_s;
      step_cnt_r <= step_cnt_s;
      is_game_r  <= is_game;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign enemy_type[3*g +: 3]  = type_r[g];
    assign enemy_pos[10*g +: 10] = pos_r[g];
    assign enemy_hp[8*g +: 8]    = hp_r[g];
  end

  assign enemy_valid = valid_r;
  assign alive_count = alive_r;
  assign radish_hp   = radish_r;
  assign death       = (radish_r == 4'd0);
  assign kill_pulse  = kill_r;
  assign leak_pulse  = leak_r;
  assign spawn_drop  = drop_r;

endmodule
